// File: rtl/router_port_rx_pkg.sv
// Shared definitions for the router output-port receiver: FSM encoding,
// header field positions and status counter width.
package router_port_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_HDR     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_PARITY  = 3'd4,
        ST_DONE    = 3'd5
    } rx_state_e;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;
    localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;
    // Byte index within a packet: header + up to 63 payload + parity.
    localparam int IDX_W    = LEN_W + 1;
    localparam int CNT_W    = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/router_port_rx.sv
// Receiver for one router output port: pulls a packet out of the port FIFO,
// streams its payload, checks address and parity, and keeps packet statistics.
module router_port_rx
    import router_port_rx_pkg::*;
#(
    parameter logic [1:0] PORT_ID    = 2'd0,
    parameter int         READ_DELAY = 2,
    parameter int         TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             vld_out,
    input  logic [7:0]       data_out,
    output logic             read_enb,
    output logic [7:0]       pl_data,
    output logic             pl_valid,
    output logic             pkt_done,
    output logic [LEN_W-1:0] pkt_len,
    output logic             parity_err,
    output logic             addr_err,
    output logic             timeout_err,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output rx_state_e        state_dbg
);

    localparam logic [4:0] DLY_LAST = (READ_DELAY > 0) ? 5'(READ_DELAY - 1) : 5'd0;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    rx_state_e        state_q, state_d;
    logic [4:0]       dly_q, dly_d;
    logic [IDX_W-1:0] issued_q, issued_d;
    logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
    logic             rd_pend_q, rd_pend_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       par_q, par_d;
    logic             hdr_addr_err_q, hdr_addr_err_d;
    logic [7:0]       idle_q, idle_d;
    logic [7:0]       pl_data_q, pl_data_d;
    logic             pl_valid_q, pl_valid_d;
    logic             pkt_done_q, pkt_done_d;
    logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
    logic             parity_err_q, parity_err_d;
    logic             addr_err_q, addr_err_d;
    logic             timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic rd_en;
    logic capture;
    logic finish;
    logic par_bad;
    logic tmo;

    always_comb begin
        state_d        = state_q;
        dly_d          = dly_q;
        issued_d       = issued_q;
        cap_idx_d      = cap_idx_q;
        rd_pend_d      = 1'b0;
        len_d          = len_q;
        par_d          = par_q;
        hdr_addr_err_d = hdr_addr_err_q;
        idle_d         = idle_q;
        pl_data_d      = pl_data_q;
        pl_valid_d     = 1'b0;
        pkt_done_d     = 1'b0;
        pkt_len_d      = pkt_len_q;
        parity_err_d   = parity_err_q;
        addr_err_d     = addr_err_q;
        timeout_err_d  = timeout_err_q;
        pkt_cnt_d      = pkt_cnt_q;
        err_cnt_d      = err_cnt_q;
        rd_en          = 1'b0;
        finish         = 1'b0;
        par_bad        = 1'b0;
        tmo            = 1'b0;
        capture        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                dly_d          = '0;
                issued_d       = '0;
                cap_idx_d      = '0;
                len_d          = '0;
                par_d          = '0;
                hdr_addr_err_d = 1'b0;
                idle_d         = '0;
                if (vld_out) begin
                    state_d = (READ_DELAY == 0) ? ST_HDR : ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (dly_q == DLY_LAST) begin
                    state_d = ST_HDR;
                end else begin
                    dly_d = dly_q + 5'd1;
                end
            end

            ST_HDR, ST_PAYLOAD, ST_PARITY: begin
                // len_q is stale until the header lands, but len+2 >= 2 covers
                // the first two reads, and the header is captured by the time
                // the third read is considered.
                rd_en     = vld_out && (issued_q < ({1'b0, len_q} + 7'd2));
                rd_pend_d = rd_en;
                if (rd_en) begin
                    issued_d = issued_q + 7'd1;
                end

                capture = rd_pend_q;
                if (capture) begin
                    idle_d    = '0;
                    cap_idx_d = cap_idx_q + 7'd1;
                    if (cap_idx_q == '0) begin
                        len_d          = data_out[LEN_MSB:LEN_LSB];
                        hdr_addr_err_d = (data_out[ADDR_MSB:ADDR_LSB] != PORT_ID);
                        par_d          = data_out;
                        state_d        = (data_out[LEN_MSB:LEN_LSB] == '0) ? ST_PARITY : ST_PAYLOAD;
                    end else if (cap_idx_q <= {1'b0, len_q}) begin
                        pl_data_d  = data_out;
                        pl_valid_d = 1'b1;
                        par_d      = par_q ^ data_out;
                        if (cap_idx_q == {1'b0, len_q}) begin
                            state_d = ST_PARITY;
                        end
                    end else begin
                        finish  = 1'b1;
                        par_bad = (data_out != par_q);
                    end
                end else if (idle_q == TMO_LAST) begin
                    finish = 1'b1;
                    tmo    = 1'b1;
                end else begin
                    idle_d = idle_q + 8'd1;
                end

                // A read issued in the cycle the timeout fires lands during
                // DONE and is dropped there.
                if (finish) begin
                    state_d       = ST_DONE;
                    pkt_done_d    = 1'b1;
                    pkt_len_d     = len_q;
                    parity_err_d  = par_bad;
                    addr_err_d    = hdr_addr_err_q;
                    timeout_err_d = tmo;
                    if (par_bad || hdr_addr_err_q || tmo) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                    end else begin
                        pkt_cnt_d = sat_inc(pkt_cnt_q);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            dly_q          <= '0;
            issued_q       <= '0;
            cap_idx_q      <= '0;
            rd_pend_q      <= 1'b0;
            len_q          <= '0;
            par_q          <= '0;
            hdr_addr_err_q <= 1'b0;
            idle_q         <= '0;
            pl_data_q      <= '0;
            pl_valid_q     <= 1'b0;
            pkt_done_q     <= 1'b0;
            pkt_len_q      <= '0;
            parity_err_q   <= 1'b0;
            addr_err_q     <= 1'b0;
            timeout_err_q  <= 1'b0;
            pkt_cnt_q      <= '0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            dly_q          <= dly_d;
            issued_q       <= issued_d;
            cap_idx_q      <= cap_idx_d;
            rd_pend_q      <= rd_pend_d;
            len_q          <= len_d;
            par_q          <= par_d;
            hdr_addr_err_q <= hdr_addr_err_d;
            idle_q         <= idle_d;
            pl_data_q      <= pl_data_d;
            pl_valid_q     <= pl_valid_d;
            pkt_done_q     <= pkt_done_d;
            pkt_len_q      <= pkt_len_d;
            parity_err_q   <= parity_err_d;
            addr_err_q     <= addr_err_d;
            timeout_err_q  <= timeout_err_d;
            pkt_cnt_q      <= pkt_cnt_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign read_enb    = rd_en;
    assign pl_data     = pl_data_q;
    assign pl_valid    = pl_valid_q;
    assign pkt_done    = pkt_done_q;
    assign pkt_len     = pkt_len_q;
    assign parity_err  = parity_err_q;
    assign addr_err    = addr_err_q;
    assign timeout_err = timeout_err_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_router_port_rx.sv
// Directed bench for router_port_rx: two instances (port 0 with short timeout,
// port 1 with zero read delay) fed from queue-modelled router port FIFOs.
module tb_router_port_rx;
    import router_port_rx_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic resetn;

    // ---- instance A: PORT_ID=0, READ_DELAY=2, TIMEOUT=8 ----
    logic       vld_a = 1'b0;
    logic [7:0] data_a;
    logic       rd_a, pl_valid_a, done_a, perr_a, aerr_a, terr_a;
    logic [7:0] pl_data_a;
    logic [5:0] len_a;
    logic [15:0] pcnt_a, ecnt_a;
    rx_state_e  st_a;

    // ---- instance B: PORT_ID=1, READ_DELAY=0, TIMEOUT=64 ----
    logic       vld_b = 1'b0;
    logic [7:0] data_b;
    logic       rd_b, pl_valid_b, done_b, perr_b, aerr_b, terr_b;
    logic [7:0] pl_data_b;
    logic [5:0] len_b;
    logic [15:0] pcnt_b, ecnt_b;
    rx_state_e  st_b;

    router_port_rx #(.PORT_ID(2'd0), .READ_DELAY(2), .TIMEOUT(8)) dut_a (
        .clk(clk), .resetn(resetn), .vld_out(vld_a), .data_out(data_a),
        .read_enb(rd_a), .pl_data(pl_data_a), .pl_valid(pl_valid_a), .pkt_done(done_a),
        .pkt_len(len_a), .parity_err(perr_a), .addr_err(aerr_a), .timeout_err(terr_a),
        .pkt_cnt(pcnt_a), .err_cnt(ecnt_a), .state_dbg(st_a)
    );

    router_port_rx #(.PORT_ID(2'd1), .READ_DELAY(0), .TIMEOUT(64)) dut_b (
        .clk(clk), .resetn(resetn), .vld_out(vld_b), .data_out(data_b),
        .read_enb(rd_b), .pl_data(pl_data_b), .pl_valid(pl_valid_b), .pkt_done(done_b),
        .pkt_len(len_b), .parity_err(perr_b), .addr_err(aerr_b), .timeout_err(terr_b),
        .pkt_cnt(pcnt_b), .err_cnt(ecnt_b), .state_dbg(st_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---- router FIFO models: read data appears the cycle after a read ----
    logic [7:0] fq_a[$];
    logic [7:0] fq_b[$];
    int rd_cnt_a = 0;
    int rd_cnt_b = 0;

    initial forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            fq_a.delete();
            fq_b.delete();
            data_a <= 8'h00;
            data_b <= 8'h00;
        end else begin
            if (rd_a && vld_a) begin
                data_a <= fq_a.pop_front();
                rd_cnt_a++;
            end
            if (rd_b && vld_b) begin
                data_b <= fq_b.pop_front();
                rd_cnt_b++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        vld_a = (fq_a.size() != 0);
        vld_b = (fq_b.size() != 0);
    end

    // ---- monitor / scoreboard ----
    logic [7:0] exp_q[$];
    int cyc = 0;
    int pl_cnt_a = 0, pl_cnt_b = 0, last_pl_cyc_a = 0;
    int done_cnt_a = 0, done_cnt_b = 0;
    logic [5:0]  rec_len_a [0:15];
    logic [2:0]  rec_flg_a [0:15];
    logic [15:0] rec_pc_a  [0:15];
    logic [15:0] rec_ec_a  [0:15];
    int          rec_rd_a  [0:15];
    int          rec_cyc_a [0:15];
    logic [5:0]  rec_len_b [0:15];
    logic [2:0]  rec_flg_b [0:15];
    logic [15:0] rec_pc_b  [0:15];
    logic [15:0] rec_ec_b  [0:15];
    int          rec_rd_b  [0:15];

    initial forever begin
        @(negedge clk);
        cyc++;
        if (pl_valid_a) begin
            pl_cnt_a++;
            last_pl_cyc_a = cyc;
            if (exp_q.size() != 0) chk("payload_a", pl_data_a, exp_q.pop_front());
        end
        if (done_a && done_cnt_a < 16) begin
            rec_len_a[done_cnt_a] = len_a;
            rec_flg_a[done_cnt_a] = {perr_a, aerr_a, terr_a};
            rec_pc_a[done_cnt_a]  = pcnt_a;
            rec_ec_a[done_cnt_a]  = ecnt_a;
            rec_rd_a[done_cnt_a]  = rd_cnt_a;
            rec_cyc_a[done_cnt_a] = cyc;
            done_cnt_a++;
        end
        if (pl_valid_b) pl_cnt_b++;
        if (done_b && done_cnt_b < 16) begin
            rec_len_b[done_cnt_b] = len_b;
            rec_flg_b[done_cnt_b] = {perr_b, aerr_b, terr_b};
            rec_pc_b[done_cnt_b]  = pcnt_b;
            rec_ec_b[done_cnt_b]  = ecnt_b;
            rec_rd_b[done_cnt_b]  = rd_cnt_b;
            done_cnt_b++;
        end
    end

    // ---- drivers ----
    task automatic send(input int port, input logic [7:0] hdr, input int n_pl,
                        input bit flip_par, input bit with_par, input bit track);
        logic [7:0] p;
        logic [7:0] b;
        @(posedge clk);
        #1;
        p = hdr;
        if (port == 0) fq_a.push_back(hdr); else fq_b.push_back(hdr);
        for (int i = 0; i < n_pl; i++) begin
            b = 8'($urandom_range(0, 255));
            p = p ^ b;
            if (port == 0) fq_a.push_back(b); else fq_b.push_back(b);
            if (track) exp_q.push_back(b);
        end
        if (with_par) begin
            b = flip_par ? (p ^ 8'h01) : p;
            if (port == 0) fq_a.push_back(b); else fq_b.push_back(b);
        end
    endtask

    task automatic wait_done(input int port, input int target);
        int n;
        n = 0;
        while (((port == 0) ? done_cnt_a : done_cnt_b) < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(port == 0 ? "done_wait_a" : "done_wait_b",
            (port == 0) ? done_cnt_a : done_cnt_b, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int base_rd, base_pl, dc, n;

    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read_enb", rd_a, 1'b0);
        chk("rst_pl_valid", pl_valid_a, 1'b0);
        chk("rst_pl_data", pl_data_a, 8'h00);
        chk("rst_pkt_done", done_a, 1'b0);
        chk("rst_pkt_len", len_a, 6'd0);
        chk("rst_flags", {perr_a, aerr_a, terr_a}, 3'b000);
        chk("rst_pkt_cnt", pcnt_a, 16'd0);
        chk("rst_err_cnt", ecnt_a, 16'd0);
        chk("rst_state", st_a, ST_IDLE);
        chk("rst_b_cnts", {pcnt_b, ecnt_b}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Port 1 receives a header addressed to port 2: whole packet consumed, flagged.
        base_rd = rd_cnt_b;
        send(1, 8'h3A, 14, 1'b0, 1'b1, 1'b0);
        wait_done(1, 1);
        chk("addr_len", rec_len_b[0], 6'd14);
        chk("addr_flags", rec_flg_b[0], 3'b010);
        chk("addr_reads", rec_rd_b[0] - base_rd, 16);
        chk("addr_err_cnt", rec_ec_b[0], 16'd1);
        chk("addr_pkt_cnt", rec_pc_b[0], 16'd0);
        chk("addr_pl_cnt", pl_cnt_b, 14);

        // Good packet, len 18.
        base_rd = rd_cnt_a;
        base_pl = pl_cnt_a;
        send(0, 8'h48, 18, 1'b0, 1'b1, 1'b1);
        wait_done(0, 1);
        chk("good_len", rec_len_a[0], 6'd18);
        chk("good_flags", rec_flg_a[0], 3'b000);
        chk("good_pkt_cnt", rec_pc_a[0], 16'd1);
        chk("good_err_cnt", rec_ec_a[0], 16'd0);
        chk("good_reads", rec_rd_a[0] - base_rd, 20);
        chk("good_pl_cnt", pl_cnt_a - base_pl, 18);

        // Same length, corrupted parity byte.
        base_pl = pl_cnt_a;
        send(0, 8'h48, 18, 1'b1, 1'b1, 1'b1);
        wait_done(0, 2);
        chk("par_flags", rec_flg_a[1], 3'b100);
        chk("par_err_cnt", rec_ec_a[1], 16'd1);
        chk("par_pkt_cnt", rec_pc_a[1], 16'd1);
        chk("par_pl_cnt", pl_cnt_a - base_pl, 18);

        // Back-to-back packets: first must stop after exactly 27 reads.
        base_rd = rd_cnt_a;
        send(0, 8'h64, 25, 1'b0, 1'b1, 1'b1);
        send(0, 8'h04, 1, 1'b0, 1'b1, 1'b1);
        wait_done(0, 4);
        chk("b2b_len0", rec_len_a[2], 6'd25);
        chk("b2b_reads0", rec_rd_a[2] - base_rd, 27);
        chk("b2b_pkt_cnt0", rec_pc_a[2], 16'd2);
        chk("b2b_len1", rec_len_a[3], 6'd1);
        chk("b2b_flags1", rec_flg_a[3], 3'b000);
        chk("b2b_pkt_cnt1", rec_pc_a[3], 16'd3);
        chk("b2b_reads1", rec_rd_a[3] - base_rd, 30);

        // Stall after 5 of 8 payload bytes: abort TIMEOUT=8 cycles after last capture.
        base_pl = pl_cnt_a;
        send(0, 8'h20, 5, 1'b0, 1'b0, 1'b1);
        wait_done(0, 5);
        chk("tmo_flags", rec_flg_a[4], 3'b001);
        chk("tmo_len", rec_len_a[4], 6'd8);
        chk("tmo_err_cnt", rec_ec_a[4], 16'd2);
        chk("tmo_pkt_cnt", rec_pc_a[4], 16'd3);
        chk("tmo_gap", rec_cyc_a[4] - last_pl_cyc_a, 8);
        chk("tmo_pl_cnt", pl_cnt_a - base_pl, 5);
        chk("exp_q_empty", exp_q.size(), 0);

        // Reset in the middle of a packet.
        base_pl = pl_cnt_a;
        send(0, 8'h20, 3, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (pl_cnt_a == base_pl && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_armed", pl_cnt_a != base_pl, 1'b1);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_read_enb", rd_a, 1'b0);
        chk("mid_rst_pl_valid", pl_valid_a, 1'b0);
        chk("mid_rst_pl_data", pl_data_a, 8'h00);
        chk("mid_rst_pkt_done", done_a, 1'b0);
        chk("mid_rst_pkt_len", len_a, 6'd0);
        chk("mid_rst_flags", {perr_a, aerr_a, terr_a}, 3'b000);
        chk("mid_rst_pkt_cnt", pcnt_a, 16'd0);
        chk("mid_rst_err_cnt", ecnt_a, 16'd0);
        chk("mid_rst_state", st_a, ST_IDLE);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        dc = done_cnt_a;
        repeat (40) @(negedge clk);
        chk("no_done_after_rst", done_cnt_a, dc);

        // Reception resumes cleanly after reset.
        send(0, 8'h08, 2, 1'b0, 1'b1, 1'b1);
        wait_done(0, dc + 1);
        chk("post_rst_len", rec_len_a[dc], 6'd2);
        chk("post_rst_flags", rec_flg_a[dc], 3'b000);
        chk("post_rst_pkt_cnt", rec_pc_a[dc], 16'd1);
        chk("post_rst_err_cnt", rec_ec_a[dc], 16'd0);
        chk("exp_q_final", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/router_port_rx.md
ROUTER_PORT_RX -- requirements
Module: router_port_rx

Interface
REQ-001 Parameter PORT_ID, 2'd0, router output port served; expected header address.
REQ-002 Parameter READ_DELAY, 2, cycles from vld_out rising to read_enb asserting; legal range 0..20.
REQ-003 Parameter TIMEOUT, 64, idle cycles mid-packet before abort; legal range 2..255.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 vld_out  in  1  router port FIFO non-empty.
REQ-007 data_out  in  8  router port FIFO read data; valid the cycle after a read.
REQ-008 read_enb  out  1  FIFO read request to router port.
REQ-009 pl_data  out  8  payload byte.
REQ-010 pl_valid  out  1  pl_data valid this cycle; one cycle per byte; no backpressure.
REQ-011 pkt_done  out  1  one-cycle pulse at packet completion or abort.
REQ-012 pkt_len  out  6  header length field of the last packet; held until next pkt_done.
REQ-013 parity_err, addr_err, timeout_err  out  1 each  status of the last packet; held until next pkt_done.
REQ-014 pkt_cnt  out  16  packets completed without error; saturating.
REQ-015 err_cnt  out  16  packets with any error flag; saturating.

Function
REQ-016 Packet format: header byte {len[5:0], addr[1:0]}, then len payload bytes, then one parity byte; len=0 means header then parity.
REQ-017 FSM states: IDLE, WAIT, HDR, PAYLOAD, PARITY, DONE.
REQ-018 IDLE -> WAIT when vld_out=1; WAIT counts READ_DELAY cycles, then -> HDR (READ_DELAY=0: IDLE -> HDR directly).
REQ-019 read_enb = 1 in HDR, PAYLOAD, PARITY while vld_out=1 and the bytes issued for the current packet < len+2; never asserted in IDLE, WAIT, DONE.
REQ-020 A read is issued when read_enb=1 and vld_out=1 at a rising edge; its byte is captured from data_out at the next rising edge (one-cycle read latency).
REQ-021 Issue counter stops read_enb after len+2 reads, so bytes of a following packet are never consumed early.
REQ-022 Captured byte 0 is the header: latch len, compare addr with PORT_ID, seed running parity with header.
REQ-023 Captured bytes 1..len: drive pl_data, pl_valid=1 in the capture cycle, XOR into running parity.
REQ-024 Captured byte len+1: parity_err = (byte != running parity); then -> DONE.
REQ-025 DONE lasts one cycle: pkt_done=1, update pkt_len and error flags, increment exactly one of pkt_cnt/err_cnt; -> IDLE.
REQ-026 Any of parity_err, addr_err, timeout_err set -> err_cnt increments; addr mismatch still consumes the whole packet.
REQ-027 Idle counter in HDR/PAYLOAD/PARITY increments each cycle with no capture, clears on capture; at TIMEOUT -> DONE with timeout_err=1, parity_err=0; remaining bytes are not drained.
REQ-028 A read in flight when timeout fires is still captured and discarded.
REQ-029 Counters saturate at 16'hFFFF; no wrap.
REQ-030 Worst-case vld_out-to-read_enb latency READ_DELAY+1 cycles, below the router's 30-cycle soft-reset window.

Reset
REQ-031 resetn=0 asynchronously forces IDLE, read_enb=0, pl_valid=0, pl_data=0, pkt_done=0, pkt_len=0, all error flags 0, pkt_cnt=0, err_cnt=0, internal counters and parity 0.
REQ-032 Reset mid-packet discards the partial packet with no pkt_done; after release, reception starts from the next vld_out.

Structure
REQ-033 Shared router package holds state encoding, header field positions (LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1, ADDR_LSB=0) and 16-bit counter width.
REQ-034 Single module; no sub-modules.

Verification
REQ-035 PORT_ID=0, header 8'h48 (len 18), 18 random bytes, correct parity -> 18 pl_valid pulses matching bytes in order, pkt_done with pkt_len=18, no error flags, pkt_cnt=1.
REQ-036 Same packet with parity byte bit-flipped -> parity_err=1, err_cnt=1, pkt_cnt unchanged, all 18 payload bytes still delivered.
REQ-037 PORT_ID=1, header 8'h3A (len 14, addr 2) -> addr_err=1, 16 reads total, err_cnt=1.
REQ-038 Header 8'h64 (len 25) followed back-to-back by header 8'h04 (len 1): read_enb drops after 27 reads; second packet completes with pkt_len=1; pkt_cnt=2.
REQ-039 TIMEOUT=8, vld_out low after 5 payload bytes -> pkt_done after 8 idle cycles, timeout_err=1; resetn pulsed mid-packet -> all outputs 0 immediately, no pkt_done.
